// File: rtl/controle_ula.sv
// ALU control: decodes ula_op/funct into the ALU seletor through a 3-state request/emit handshake.
// Optional: define CONTROLE_ULA_NOR_EN to make funct 100111 a legal NOR (seletor 1100).
module controle_ula (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ula_op,
  input  logic [5:0] funct,
  input  logic       valido_entrada,
  output logic       pronto_entrada,
  output logic [3:0] seletor,
  output logic       valido_saida,
  input  logic       pronto,
  output logic       erro,
  output logic [7:0] contador
);

  typedef enum logic [1:0] {OCIOSO, DECODIFICA, EMITE} estado_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] funct;
  } req_t;

  estado_t estado;
  req_t    req;

  // Returns {erro, seletor}; every illegal request falls back to an add with erro set.
  function automatic logic [4:0] decodifica(input req_t r);
    logic [4:0] d;
    d = {1'b1, 4'b0010};
    case (r.op)
      2'b00: d = {1'b0, 4'b0010};
      2'b01: d = {1'b0, 4'b0110};
      2'b10: begin
        case (r.funct)
          6'b100000: d = {1'b0, 4'b0010};
          6'b100010: d = {1'b0, 4'b0110};
          6'b100100: d = {1'b0, 4'b0000};
          6'b100101: d = {1'b0, 4'b0001};
          6'b101010: d = {1'b0, 4'b0111};
`ifdef CONTROLE_ULA_NOR_EN
          6'b100111: d = {1'b0, 4'b1100};
`else
          6'b100111: d = {1'b1, 4'b0010};
`endif
          default:   d = {1'b1, 4'b0010};
        endcase
      end
      default: d = {1'b1, 4'b0010};
    endcase
    return d;
  endfunction

  assign pronto_entrada = (estado == OCIOSO) && !reset;
  assign valido_saida   = (estado == EMITE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      req      <= '0;
      seletor  <= 4'b0000;
      erro     <= 1'b0;
      contador <= 8'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido_entrada) begin
            req    <= '{op: ula_op, funct: funct};
            estado <= DECODIFICA;
          end
        end
        DECODIFICA: begin
          {erro, seletor} <= decodifica(req);
          estado          <= EMITE;
        end
        EMITE: begin
          // Exit cycle goes to OCIOSO, so the next accept is at least 3 cycles later.
          if (pronto) begin
            contador <= contador + 8'd1;
            estado   <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
